// File: rtl/spi_unit_responder.sv
// SPI responder front-end for coprocessor units. It receives an opcode and two
// operands from the CPU master, hands them to a compute core over valid/ready,
// and shifts the core's result back out on miso during the receive window.
module spi_unit_responder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned WAIT_CYCLES = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [OP_W-1:0]   core_op,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              frame_abort,
    output logic              late_err
);

    localparam int unsigned CNT_MAX0 = (DATA_W > WAIT_CYCLES) ? DATA_W : WAIT_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > OP_W) ? CNT_MAX0 : OP_W;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {StIdle, StRxOp, StRxA, StRxB, StWait, StTx, StDone} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, nss_sync;
    logic                   sclk_prev, nss_prev;
    logic                   sclk_s, mosi_s, nss_s;
    logic                   rise, fall, nss_fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OP_W-1:0]        op_sr_q, op_sr_d;
    logic [DATA_W-1:0]      a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d, res_q, res_d;
    logic                   held_q, held_d;
    logic                   miso_q, miso_d, cv_q, cv_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [DATA_W-1:0]      ca_q, ca_d, cb_q, cb_d;
    logic                   abort_q, abort_d, late_q, late_d;
    logic [DATA_W-1:0]      b_new;

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign nss_s    = nss_sync[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_prev;
    assign fall     = ~sclk_s & sclk_prev;
    assign nss_fall = ~nss_s & nss_prev;
    assign b_new    = {b_sr_q[DATA_W-2:0], mosi_s};

    // Synchronise the SPI inputs and keep previous values for edge detection.
    // nss resets high (deselected) so release of reset never looks like a frame start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            nss_sync  <= '1;
            sclk_prev <= 1'b0;
            nss_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
            sclk_prev <= sclk_s;
            nss_prev  <= nss_s;
        end
    end

    // Frame state, shift registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_sr_q <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            tx_sr_q <= '0;
            res_q   <= '0;
            held_q  <= 1'b0;
            miso_q  <= 1'b0;
            cv_q    <= 1'b0;
            op_q    <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            abort_q <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_sr_q <= op_sr_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            tx_sr_q <= tx_sr_d;
            res_q   <= res_d;
            held_q  <= held_d;
            miso_q  <= miso_d;
            cv_q    <= cv_d;
            op_q    <= op_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            abort_q <= abort_d;
            late_q  <= late_d;
        end
    end

    // Next-state logic: abort has priority over any coincident sclk edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_sr_d = op_sr_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        tx_sr_d = tx_sr_q;
        res_d   = res_q;
        held_d  = held_q;
        miso_d  = miso_q;
        cv_d    = cv_q;
        op_d    = op_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        abort_d = 1'b0;
        late_d  = 1'b0;

        if (cv_q && core_ready) cv_d = 1'b0;

        if (nss_s && (state_q != StIdle) && (state_q != StDone)) begin
            state_d = StIdle;
            cnt_d   = '0;
            abort_d = 1'b1;
            cv_d    = 1'b0;
            miso_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (nss_fall) begin
                        state_d = StRxOp;
                        cnt_d   = '0;
                        held_d  = 1'b0;
                    end
                end
                StRxOp: begin
                    if (rise) begin
                        op_sr_d = {op_sr_q[OP_W-2:0], mosi_s};
                        if (cnt_q == CNT_W'(OP_W - 1)) begin
                            state_d = StRxA;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + 1'b1;
                    end
                end
                StRxA: begin
                    if (rise) begin
                        a_sr_d = {a_sr_q[DATA_W-2:0], mosi_s};
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = StRxB;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + 1'b1;
                    end
                end
                StRxB: begin
                    if (rise) begin
                        b_sr_d = b_new;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            op_d    = op_sr_q;
                            ca_d    = a_sr_q;
                            cb_d    = b_new;
                            cv_d    = 1'b1;
                            state_d = StWait;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    if (rsp_valid) begin
                        res_d  = rsp_data;
                        held_d = 1'b1;
                    end
                    if (rise) begin
                        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                            // A result arriving on this very cycle still counts as in time.
                            if (held_d) begin
                                tx_sr_d = res_d;
                                miso_d  = res_d[DATA_W-1];
                            end else begin
                                tx_sr_d = '0;
                                miso_d  = 1'b0;
                                late_d  = 1'b1;
                                cv_d    = 1'b0;
                            end
                            state_d = StTx;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + 1'b1;
                    end
                end
                StTx: begin
                    // Change miso only after a fall so the master gets half a period of setup.
                    if (fall) begin
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = StDone;
                            miso_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            miso_d = tx_sr_q[DATA_W-2];
                            cnt_d  = cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    miso_d = 1'b0;
                    if (nss_s) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign miso        = miso_q;
    assign core_valid  = cv_q;
    assign core_op     = op_q;
    assign core_a      = ca_q;
    assign core_b      = cb_q;
    assign frame_abort = abort_q;
    assign late_err    = late_q;

endmodule

// File: tb/tb_spi_unit_responder.sv
// Bench for spi_unit_responder: acts as SPI master and as the attached core.
module tb_spi_unit_responder;

    localparam int HALF = 80;  // half sclk period; system clock period is 10

    logic        clock, reset, sclk, nss, mosi, miso;
    logic        core_valid, core_ready, rsp_valid, frame_abort, late_err;
    logic [3:0]  core_op;
    logic [31:0] core_a, core_b, rsp_data;

    int checks = 0;
    int errors = 0;

    // core model knobs
    int          ready_delay = 0;
    int          rsp_delay   = 3;
    logic [31:0] rsp_value   = '0;

    // monitor counters
    int late_cnt = 0, abort_cnt = 0, cv_cycles = 0, drop_err = 0, unstable = 0;
    bit cv_seen = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rsp;
        int          rdy;
        int          dly;
        int          late;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    spi_unit_responder dut (
        .clock      (clock),
        .reset      (reset),
        .sclk       (sclk),
        .nss        (nss),
        .mosi       (mosi),
        .miso       (miso),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_op    (core_op),
        .core_a     (core_a),
        .core_b     (core_b),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .frame_abort(frame_abort),
        .late_err   (late_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One SPI frame: 68 data rises, 8 wait rises, then 32 result falls sampled by the master.
    // abort_at: raise nss right after that fall number; rst_at: reset on that result fall.
    task automatic run_frame(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int abort_at, input int rst_at, input int gap,
                             output logic [31:0] rx);
        logic [67:0] bits;
        bits = {op, a, b};
        rx   = '0;
        nss  = 1'b0;
        for (int k = 1; k <= 107; k++) begin
            if (k <= 68) mosi = bits[68-k];
            #HALF;
            sclk = 1'b1;
            #HALF;
            if (k >= 76) begin
                rx = {rx[30:0], miso};
                if (rst_at != 0 && (k - 75) == rst_at) begin
                    reset = 1'b0;
                    #1;
                    check("rst_miso", {31'd0, miso}, 32'd0);
                    check("rst_core_valid", {31'd0, core_valid}, 32'd0);
                    check("rst_core_a", core_a, 32'd0);
                    sclk = 1'b0;
                    nss  = 1'b1;
                    mosi = 1'b0;
                    #20;
                    reset = 1'b1;
                    #(4 * HALF);
                    return;
                end
            end
            sclk = 1'b0;
            if (abort_at == k) begin
                nss  = 1'b1;
                mosi = 1'b0;
                #(4 * HALF);
                return;
            end
        end
        #HALF;
        nss  = 1'b1;
        mosi = 1'b0;
        #gap;
    endtask

    // Core model: asserts ready after ready_delay valid cycles, answers rsp_delay cycles later.
    initial begin : core_model
        int vcnt;
        int rcnt;
        bit armed;
        vcnt  = 0;
        rcnt  = 0;
        armed = 0;
        forever begin
            @(posedge clock);
            #1;
            rsp_valid = 1'b0;
            if (core_ready) begin
                core_ready = 1'b0;
                armed      = 1;
                rcnt       = rsp_delay;
                vcnt       = 0;
            end else if (core_valid) begin
                if (vcnt >= ready_delay) core_ready = 1'b1;
                else vcnt++;
            end else vcnt = 0;
            if (armed) begin
                if (rcnt <= 1) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rsp_value;
                    armed     = 0;
                end else rcnt--;
            end
        end
    end

    // Monitor: pulse counts, valid drop after handshake, operand stability while valid.
    initial begin : monitor
        logic        prev_hs, prev_cv;
        logic [3:0]  po;
        logic [31:0] pa, pb;
        prev_hs = 0;
        prev_cv = 0;
        po = '0;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clock);
            if (late_err) late_cnt++;
            if (frame_abort) abort_cnt++;
            if (core_valid) begin
                cv_cycles++;
                cv_seen = 1;
            end
            if (prev_hs && core_valid) drop_err++;
            if (prev_cv && core_valid && (core_a != pa || core_b != pb || core_op != po))
                unstable++;
            prev_hs = core_valid && core_ready;
            prev_cv = core_valid;
            po = core_op;
            pa = core_a;
            pb = core_b;
        end
    end

    initial begin
        logic [31:0] rx, rx2;
        int late0, abort0, cv0;

        reset = 1'b0;
        sclk = 1'b0;
        nss = 1'b1;
        mosi = 1'b0;
        core_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;

        vecs[0] = '{4'h9, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0, 3, 0, 32'h0000_000F};
        vecs[1] = '{4'h3, 32'h1111_2222, 32'h3333_4444, 32'hA5A5_5A5A, 20, 3, 0, 32'hA5A5_5A5A};
        vecs[2] = '{4'h2, 32'h0000_0010, 32'h0000_0020, 32'hDEAD_BEEF, 0, 200, 1, 32'h0};
        vecs[3] = '{4'h5, 32'h0000_0001, 32'h0000_0001, 32'h1357_9BDF, 1000, 0, 1, 32'h0};
        vecs[4] = '{4'hF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 2, 1, 0, 32'h8000_0001};
        vecs[5] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0, 1, 0, 32'h7FFF_FFFF};

        repeat (3) @(negedge clock);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_core_valid", {31'd0, core_valid}, 32'd0);
        check("reset_core_op", {28'd0, core_op}, 32'd0);
        check("reset_core_a", core_a, 32'd0);
        check("reset_core_b", core_b, 32'd0);
        check("reset_pulses", {30'd0, frame_abort, late_err}, 32'd0);
        reset = 1'b1;
        #(4 * HALF);

        for (int i = 0; i < 6; i++) begin
            ready_delay = vecs[i].rdy;
            rsp_delay   = vecs[i].dly;
            rsp_value   = vecs[i].rsp;
            late0  = late_cnt;
            abort0 = abort_cnt;
            cv0    = cv_cycles;
            run_frame(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 4 * HALF, rx);
            check($sformatf("v%0d_core_op", i), {28'd0, core_op}, {28'd0, vecs[i].op});
            check($sformatf("v%0d_core_a", i), core_a, vecs[i].a);
            check($sformatf("v%0d_core_b", i), core_b, vecs[i].b);
            check($sformatf("v%0d_miso_stream", i), rx, vecs[i].exp);
            check($sformatf("v%0d_late_pulses", i), late_cnt - late0, vecs[i].late);
            check($sformatf("v%0d_abort_pulses", i), abort_cnt - abort0, 32'd0);
            check($sformatf("v%0d_valid_low", i), {31'd0, core_valid}, 32'd0);
            if (vecs[i].rdy < 100)
                check($sformatf("v%0d_valid_hold", i),
                      {31'd0, (cv_cycles - cv0) == vecs[i].rdy + 1}, 32'd1);
        end

        // Abort after 10 bits of operand A; nss rises together with an sclk fall.
        ready_delay = 0;
        rsp_delay   = 3;
        rsp_value   = 32'h5555_AAAA;
        cv_seen     = 0;
        abort0      = abort_cnt;
        run_frame(4'h6, 32'hABCD_1234, 32'h0000_0001, 14, 0, 0, rx);
        check("abort_pulses", abort_cnt - abort0, 32'd1);
        check("abort_no_valid", {31'd0, cv_seen}, 32'd0);
        check("abort_miso", {31'd0, miso}, 32'd0);
        rsp_value = 32'h0000_0009;
        run_frame(4'h1, 32'h0000_0007, 32'h0000_0002, 0, 0, 4 * HALF, rx);
        check("post_abort_op", {28'd0, core_op}, 32'd1);
        check("post_abort_a", core_a, 32'd7);
        check("post_abort_b", core_b, 32'd2);
        check("post_abort_result", rx, 32'h0000_0009);

        // Back-to-back frames separated by one sclk period of nss high.
        rsp_value = 32'h1234_5678;
        run_frame(4'h7, 32'h0000_1000, 32'h0000_2000, 0, 0, 2 * HALF, rx);
        rsp_value = 32'hFFFF_FFFE;
        run_frame(4'h8, 32'h0000_3000, 32'h0000_4000, 0, 0, 4 * HALF, rx2);
        check("b2b_first", rx, 32'h1234_5678);
        check("b2b_second", rx2, 32'hFFFF_FFFE);
        check("b2b_second_b", core_b, 32'h0000_4000);

        // Reset on result bit 12; upper 12 bits were already shifted out.
        rsp_value = 32'h00F0_0F00;
        run_frame(4'hA, 32'h0000_0011, 32'h0000_0022, 0, 12, 0, rx);
        check("rst_partial_bits", {20'd0, rx[11:0]}, 32'h0000_000F);
        rsp_value = 32'h0000_0017;
        run_frame(4'h4, 32'h0000_0008, 32'h0000_0009, 0, 0, 4 * HALF, rx);
        check("post_rst_result", rx, 32'h0000_0017);
        check("post_rst_op", {28'd0, core_op}, 32'd4);

        check("valid_drop_after_ready", drop_err, 32'd0);
        check("operands_stable", unstable, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
